// File: rtl/spi_master_cfg_pkg.sv
// rtl/spi_master_cfg_pkg.sv - shared FSM state codes and width helper for the SPI master
package spi_master_cfg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  function automatic int clog2_f(input int value);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_master_cfg_sck_gen.sv
// rtl/spi_master_cfg_sck_gen.sv - SCK divider; strobes mark the CLK_26 cycle where SCK changes
module spi_master_cfg_sck_gen #(
  parameter int SCK_DIV = 4,
  parameter int CPOL    = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_shift,
  output logic o_wrap,
  output logic o_lead,
  output logic o_trail,
  output logic o_sck
);
  import spi_master_cfg_pkg::*;

  localparam int              DIV_W    = clog2_f(SCK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic            IDLE_LVL = 1'(CPOL);

  logic [DIV_W-1:0] r_div;
  logic             r_sck;
  logic             w_wrap;
  logic             w_edge;

  assign w_wrap  = i_run && (r_div == DIV_LAST);
  assign w_edge  = w_wrap && i_shift;
  assign o_wrap  = w_wrap;
  assign o_lead  = w_edge && (r_sck == IDLE_LVL);
  assign o_trail = w_edge && (r_sck != IDLE_LVL);
  assign o_sck   = r_sck;

  // The divider runs through SETUP/HOLD too so the FSM can time those phases; SCK only moves in SHIFT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_sck <= IDLE_LVL;
    end else begin
      if (!i_run || w_wrap) r_div <= '0;
      else                  r_div <= r_div + DIV_W'(1);
      if (w_edge) r_sck <= ~r_sck;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - parametrised full-duplex MSB-first SPI master with N chip selects
module spi_master_cfg #(
  parameter int DATA_W  = 16,
  parameter int SCK_DIV = 4,
  parameter int SEL_W   = 2,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0
) (
  input  logic                 i_clk_26,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic [DATA_W-1:0]    i_tx_data,
  input  logic                 i_miso,
  output logic                 o_sck,
  output logic                 o_mosi,
  output logic [2**SEL_W-1:0]  o_ss,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_W-1:0]    o_rx_data
);
  import spi_master_cfg_pkg::*;

  localparam int              N_SS     = 2**SEL_W;
  localparam int              BIT_W    = clog2_f(2*DATA_W + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*DATA_W - 1);

  logic [1:0]        r_state;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_mosi;
  logic [N_SS-1:0]   r_ss;
  logic              r_busy;
  logic              r_done;

  logic w_wrap, w_lead, w_trail, w_sck;
  logic w_sample, w_drive;

  spi_master_cfg_sck_gen #(
    .SCK_DIV (SCK_DIV),
    .CPOL    (CPOL)
  ) u_sck_gen (
    .i_clk   (i_clk_26),
    .i_rst_n (i_rst_n),
    .i_run   (r_state != ST_IDLE),
    .i_shift (r_state == ST_SHIFT),
    .o_wrap  (w_wrap),
    .o_lead  (w_lead),
    .o_trail (w_trail),
    .o_sck   (w_sck)
  );

  // CPHA=0 presents bit 0 during SETUP, so its final trailing edge must not advance MOSI.
  assign w_sample = (CPHA == 0) ? w_lead : w_trail;
  assign w_drive  = (CPHA == 0) ? (w_trail && (r_bit != BIT_LAST)) : w_lead;

  always_ff @(posedge i_clk_26 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_mosi    <= 1'b0;
      r_ss      <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SETUP;
            r_busy  <= 1'b1;
            r_bit   <= '0;
            r_ss    <= ~(N_SS'(1) << i_sel);
            if (CPHA == 0) begin
              r_mosi <= i_tx_data[DATA_W-1];
              r_tx   <= i_tx_data << 1;
            end else begin
              r_tx   <= i_tx_data;
            end
          end
        end
        ST_SETUP: begin
          if (w_wrap) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_wrap) begin
            r_bit <= r_bit + BIT_W'(1);
            if (r_bit == BIT_LAST) r_state <= ST_HOLD;
          end
          if (w_sample) r_rx <= {r_rx[DATA_W-2:0], i_miso};
          if (w_drive) begin
            r_mosi <= r_tx[DATA_W-1];
            r_tx   <= r_tx << 1;
          end
        end
        ST_HOLD: begin
          if (w_wrap) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_ss      <= '1;
            r_mosi    <= 1'b0;
            r_rx_data <= r_rx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sck     = w_sck;
  assign o_mosi    = r_mosi;
  assign o_ss      = r_ss;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - scoreboard bench for spi_master_cfg across three configurations
module tb_spi_master_cfg;

  localparam logic [2:0] IDLE_LVL = 3'b010;

  typedef struct {
    int          inst;
    logic [15:0] rx;
    int          len;
    logic [3:0]  ss;
    int          pulses;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic [2:0]  sck, mosi, busy, done;
  logic [1:0]  sel [3];
  logic [15:0] tx [3];
  logic [3:0]  ss [3];
  logic [7:0]  rx0, rx1;
  logic [15:0] rx2;
  logic        miso0, miso1, miso2;
  logic [7:0]  slv_tx = '0, slv_rx = '0;

  exp_t sb[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   cnt [3], pul [3];
  logic [3:0] ss_first [3];
  logic [2:0] ss_bad = '0;
  logic [2:0] prev = '0;

  always #5 clk = ~clk;

  assign miso0 = mosi[0];
  assign miso2 = mosi[2];

  spi_master_cfg #(.DATA_W(8), .SCK_DIV(4), .SEL_W(2), .CPOL(0), .CPHA(0)) u_m0 (
    .i_clk_26(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_sel(sel[0]),
    .i_tx_data(tx[0][7:0]), .i_miso(miso0), .o_sck(sck[0]), .o_mosi(mosi[0]),
    .o_ss(ss[0]), .o_busy(busy[0]), .o_done(done[0]), .o_rx_data(rx0));

  spi_master_cfg #(.DATA_W(8), .SCK_DIV(4), .SEL_W(2), .CPOL(1), .CPHA(1)) u_m3 (
    .i_clk_26(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_sel(sel[1]),
    .i_tx_data(tx[1][7:0]), .i_miso(miso1), .o_sck(sck[1]), .o_mosi(mosi[1]),
    .o_ss(ss[1]), .o_busy(busy[1]), .o_done(done[1]), .o_rx_data(rx1));

  spi_master_cfg #(.DATA_W(16), .SCK_DIV(1), .SEL_W(2), .CPOL(0), .CPHA(0)) u_w16 (
    .i_clk_26(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_sel(sel[2]),
    .i_tx_data(tx[2]), .i_miso(miso2), .o_sck(sck[2]), .o_mosi(mosi[2]),
    .o_ss(ss[2]), .o_busy(busy[2]), .o_done(done[2]), .o_rx_data(rx2));

  // Mode-3 slave: drives MISO on the falling (leading) edge, captures MOSI on the rising edge.
  always @(negedge sck[1]) begin
    miso1  = slv_tx[7];
    slv_tx = slv_tx << 1;
  end
  always @(posedge sck[1]) slv_rx = {slv_rx[6:0], mosi[1]};

  function automatic logic [15:0] rxv(input int k);
    case (k)
      0:       return {8'h00, rx0};
      1:       return {8'h00, rx1};
      default: return rx2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        cnt[k] = 0; pul[k] = 0; ss_bad[k] = 1'b0;
      end else begin
        if (busy[k]) begin
          if (cnt[k] == 0) ss_first[k] = ss[k];
          else if (ss[k] != ss_first[k]) ss_bad[k] = 1'b1;
          cnt[k]++;
        end
        if (sck[k] != prev[k] && sck[k] != IDLE_LVL[k]) pul[k]++;
        if (done[k]) begin
          chk($sformatf("sb_has_entry_%0d", k), 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("done_inst_%0d", k), 32'(k), 32'(e.inst));
            chk($sformatf("rx_data_%0d", k), 32'(rxv(k)), 32'(e.rx));
            chk($sformatf("busy_len_%0d", k), 32'(cnt[k]), 32'(e.len));
            chk($sformatf("frame_ss_%0d", k), 32'(ss_first[k]), 32'(e.ss));
            chk($sformatf("ss_stable_%0d", k), 32'(ss_bad[k]), 32'd0);
            chk($sformatf("sck_pulses_%0d", k), 32'(pul[k]), 32'(e.pulses));
            chk($sformatf("ss_idle_at_done_%0d", k), 32'(ss[k]), 32'hf);
            chk($sformatf("busy_low_at_done_%0d", k), 32'(busy[k]), 32'd0);
          end
          cnt[k] = 0; pul[k] = 0; ss_bad[k] = 1'b0;
        end
      end
      prev[k] = sck[k];
    end
  end

  task automatic go(input int k, input logic [1:0] s, input logic [15:0] t);
    @(negedge clk);
    start[k] = 1'b1; sel[k] = s; tx[k] = t;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    bit seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done[k]) begin seen = 1'b1; break; end
    end
    chk($sformatf("done_seen_%0d", k), 32'(seen), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin sel[k] = '0; tx[k] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(sck), 32'(IDLE_LVL));
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ss", 32'(ss[0]), 32'hf);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx0), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sb.push_back('{0, 16'h00A5, 72, 4'b1101, 8});
    go(0, 2'd1, 16'h00A5);
    wait_done(0);

    slv_tx = 8'h3C; slv_rx = 8'h00;
    sb.push_back('{1, 16'h003C, 72, 4'b1011, 8});
    go(1, 2'd2, 16'h00C3);
    wait_done(1);
    chk("slave_rx", 32'(slv_rx), 32'hC3);
    @(negedge clk);
    chk("mode3_sck_idle", 32'(sck[1]), 32'd1);

    sb.push_back('{0, 16'h005A, 72, 4'b1110, 8});
    go(0, 2'd0, 16'h005A);
    repeat (10) @(negedge clk);
    start[0] = 1'b1; sel[0] = 2'd3; tx[0] = 16'h00FF;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    start[0] = 1'b1; sel[0] = 2'd3; tx[0] = 16'h0066;
    sb.push_back('{0, 16'h0066, 72, 4'b0111, 8});
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b_busy", 32'(busy[0]), 32'd1);
    chk("b2b_ss", 32'(ss[0]), 32'h7);
    wait_done(0);

    sb.push_back('{2, 16'h8001, 34, 4'b1101, 16});
    go(2, 2'd1, 16'h8001);
    wait_done(2);

    go(0, 2'd2, 16'h0077);
    repeat (20) @(negedge clk);
    chk("abort_busy_before", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ss", 32'(ss[0]), 32'hf);
    chk("abort_sck", 32'(sck[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_done", 32'(done[0]), 32'd0);
    chk("abort_rx", 32'(rx0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
